// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes used by AXI4-Lite responders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_regs_decode.sv
// Register-bank address decoder: byte address -> word index, range hit, read-only flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever address is presented.
// Ports: addr (byte address in); idx (word index out); in_range (address maps to a
//        register); is_ro (mapped register is read-only, only meaningful with in_range).
module axi_lite_regs_decode #(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          NumRegs   = 8,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter logic [NumRegs-1:0]   RoMask    = '0,
   localparam int unsigned         IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
   input  logic [AddrWidth-1:0] addr,
   output logic [IdxWidth-1:0]  idx,
   output logic                 in_range,
   output logic                 is_ro
);

   localparam int unsigned ByteShift = $clog2(DataWidth / 8);

   logic [AddrWidth-1:0] off;
   logic [AddrWidth-1:0] word;

   always_comb begin
      off      = addr - BaseAddr;
      // Low byte-offset bits drop out here, so unaligned addresses hit the enclosing word.
      word     = off >> ByteShift;
      // The addr >= BaseAddr term rejects addresses that wrapped in the subtraction.
      in_range = (addr >= BaseAddr) && (word < AddrWidth'(NumRegs));
      idx      = word[IdxWidth-1:0];
      is_ro    = 1'b0;
      for (int i = 0; i < int'(NumRegs); i++) begin
         if (in_range && (idx == IdxWidth'(i))) begin
            is_ro = RoMask[i];
         end
      end
   end

endmodule

// File: rtl/axi_lite_regs_slave.sv
// AXI4-Lite responder for a bank of NumRegs registers (read-write held here, read-only from ro_data_i).
// Latency: write B two cycles after the later of AW/W handshakes; read R one cycle after AR.
// Backpressure: one-entry AW and W holding slots; B and R held stable until accepted.
// Ports: AXI4-Lite AW/W/B/AR/R channels; reg_q_o (read-write register contents, read-only
//        slices zero); reg_wr_o (one-cycle per-register write pulse); ro_data_i (read-only values).
module axi_lite_regs_slave
   import axi_pkg::*;
#(
   parameter int unsigned                   AddrWidth = 32,
   parameter int unsigned                   DataWidth = 32,
   parameter int unsigned                   NumRegs   = 8,
   parameter logic [AddrWidth-1:0]          BaseAddr  = '0,
   parameter logic [NumRegs-1:0]            RoMask    = '0,
   parameter logic [NumRegs*DataWidth-1:0]  ResetVal  = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [AddrWidth-1:0]          aw_addr_i,
   input  logic [2:0]                    aw_prot_i,
   input  logic                          aw_valid_i,
   output logic                          aw_ready_o,
   input  logic [DataWidth-1:0]          w_data_i,
   input  logic [DataWidth/8-1:0]        w_strb_i,
   input  logic                          w_valid_i,
   output logic                          w_ready_o,
   output logic [1:0]                    b_resp_o,
   output logic                          b_valid_o,
   input  logic                          b_ready_i,
   input  logic [AddrWidth-1:0]          ar_addr_i,
   input  logic [2:0]                    ar_prot_i,
   input  logic                          ar_valid_i,
   output logic                          ar_ready_o,
   output logic [DataWidth-1:0]          r_data_o,
   output logic [1:0]                    r_resp_o,
   output logic                          r_valid_o,
   input  logic                          r_ready_i,
   output logic [NumRegs*DataWidth-1:0]  reg_q_o,
   output logic [NumRegs-1:0]            reg_wr_o,
   input  logic [NumRegs*DataWidth-1:0]  ro_data_i
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;

   logic                 aw_full;
   logic                 w_full;
   logic [AddrWidth-1:0] aw_addr_q;
   logic [DataWidth-1:0] w_data_q;
   logic [StrbWidth-1:0] w_strb_q;
   logic [DataWidth-1:0] regs [NumRegs];

   logic [IdxWidth-1:0]  wr_idx;
   logic                 wr_in_range;
   logic                 wr_is_ro;
   logic [IdxWidth-1:0]  rd_idx;
   logic                 rd_in_range;
   logic                 rd_is_ro;
   resp_t                wr_resp;
   resp_t                rd_resp;
   logic [DataWidth-1:0] rd_val;
   logic                 commit;

   // Protection attributes carry no meaning for this register bank.
   logic unused_prot;
   assign unused_prot = ^{aw_prot_i, ar_prot_i, rd_is_ro};

   axi_lite_regs_decode #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .BaseAddr  (BaseAddr),
      .RoMask    (RoMask)
   ) u_wr_decode (
      .addr     (aw_addr_q),
      .idx      (wr_idx),
      .in_range (wr_in_range),
      .is_ro    (wr_is_ro)
   );

   axi_lite_regs_decode #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .BaseAddr  (BaseAddr),
      .RoMask    (RoMask)
   ) u_rd_decode (
      .addr     (ar_addr_i),
      .idx      (rd_idx),
      .in_range (rd_in_range),
      .is_ro    (rd_is_ro)
   );

   assign aw_ready_o = !aw_full;
   assign w_ready_o  = !w_full;
   assign ar_ready_o = !r_valid_o || r_ready_i;
   // A B handshake in this cycle frees the response slot, so commit may overlap it.
   assign commit     = aw_full && w_full && (!b_valid_o || b_ready_i);

   always_comb begin
      wr_resp = !wr_in_range ? RESP_DECERR : (wr_is_ro ? RESP_SLVERR : RESP_OKAY);
      rd_resp = rd_in_range ? RESP_OKAY : RESP_DECERR;
      rd_val  = '0;
      for (int i = 0; i < int'(NumRegs); i++) begin
         if (rd_in_range && (rd_idx == IdxWidth'(i))) begin
            rd_val = RoMask[i] ? ro_data_i[i*DataWidth +: DataWidth] : regs[i];
         end
      end
   end

   for (genvar g = 0; g < int'(NumRegs); g++) begin : g_reg_q
      assign reg_q_o[g*DataWidth +: DataWidth] = RoMask[g] ? '0 : regs[g];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_o <= 1'b0;
         b_resp_o  <= RESP_OKAY;
         r_valid_o <= 1'b0;
         r_resp_o  <= RESP_OKAY;
         r_data_o  <= '0;
         reg_wr_o  <= '0;
         for (int i = 0; i < int'(NumRegs); i++) begin
            regs[i] <= ResetVal[i*DataWidth +: DataWidth];
         end
      end else begin
         reg_wr_o <= '0;

         if (aw_valid_i && aw_ready_o) begin
            aw_full   <= 1'b1;
            aw_addr_q <= aw_addr_i;
         end
         if (w_valid_i && w_ready_o) begin
            w_full   <= 1'b1;
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
         end

         if (b_valid_o && b_ready_i) begin
            b_valid_o <= 1'b0;
         end

         // Holding slots are full during commit, so no new AW/W capture can collide with the clear.
         if (commit) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            b_valid_o <= 1'b1;
            b_resp_o  <= wr_resp;
            if (wr_resp == RESP_OKAY) begin
               for (int i = 0; i < int'(NumRegs); i++) begin
                  if (wr_idx == IdxWidth'(i)) begin
                     reg_wr_o[i] <= 1'b1;
                     for (int b = 0; b < int'(StrbWidth); b++) begin
                        if (w_strb_q[b]) begin
                           regs[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                     end
                  end
               end
            end
         end

         if (ar_valid_i && ar_ready_o) begin
            r_valid_o <= 1'b1;
            r_data_o  <= rd_val;
            r_resp_o  <= rd_resp;
         end else if (r_ready_i) begin
            r_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_regs_slave.sv
// Directed bench for axi_lite_regs_slave: scoreboarded B/R responses plus direct output checks.
// Latency: n/a.
// Backpressure: exercises B and R stalls and reset with transactions in flight.
module tb_axi_lite_regs_slave;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  aw_addr = '0;
   logic [2:0]   aw_prot = '0;
   logic         aw_valid = 1'b0;
   logic         aw_ready;
   logic [31:0]  w_data = '0;
   logic [3:0]   w_strb = '0;
   logic         w_valid = 1'b0;
   logic         w_ready;
   logic [1:0]   b_resp;
   logic         b_valid;
   logic         b_ready = 1'b1;
   logic [31:0]  ar_addr = '0;
   logic [2:0]   ar_prot = '0;
   logic         ar_valid = 1'b0;
   logic         ar_ready;
   logic [31:0]  r_data;
   logic [1:0]   r_resp;
   logic         r_valid;
   logic         r_ready = 1'b1;
   logic [255:0] reg_q;
   logic [7:0]   reg_wr;
   logic [255:0] ro_data = '0;

   int errors = 0;
   int checks = 0;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];
   logic [31:0] model [8];
   int          pulses [8];
   logic [7:0]  prev_wr = '0;

   always #5 clk = ~clk;

   axi_lite_regs_slave #(
      .AddrWidth (32),
      .DataWidth (32),
      .NumRegs   (8),
      .BaseAddr  (32'h0),
      .RoMask    (8'h04),
      .ResetVal  (256'h0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .aw_addr_i  (aw_addr),
      .aw_prot_i  (aw_prot),
      .aw_valid_i (aw_valid),
      .aw_ready_o (aw_ready),
      .w_data_i   (w_data),
      .w_strb_i   (w_strb),
      .w_valid_i  (w_valid),
      .w_ready_o  (w_ready),
      .b_resp_o   (b_resp),
      .b_valid_o  (b_valid),
      .b_ready_i  (b_ready),
      .ar_addr_i  (ar_addr),
      .ar_prot_i  (ar_prot),
      .ar_valid_i (ar_valid),
      .ar_ready_o (ar_ready),
      .r_data_o   (r_data),
      .r_resp_o   (r_resp),
      .r_valid_o  (r_valid),
      .r_ready_i  (r_ready),
      .reg_q_o    (reg_q),
      .reg_wr_o   (reg_wr),
      .ro_data_i  (ro_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: 8 words, reg 2 read-only, anything at or above 0x20 undecoded.
   function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit wr);
      if (a >= 32'h20) return 2'b11;
      if (wr && (a[4:2] == 3'd2)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [33:0] exp_rd(input logic [31:0] a);
      logic [1:0] r = exp_resp(a, 1'b0);
      if (r == 2'b11) return {32'h0, r};
      if (a[4:2] == 3'd2) return {ro_data[95:64], r};
      return {model[a[4:2]], r};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (exp_resp(a, 1'b1) == 2'b00) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   function automatic int pulse_sum();
      int s = 0;
      for (int i = 0; i < 8; i++) s += pulses[i];
      return s;
   endfunction

   // Response scoreboard and write-pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (b_valid && b_ready) begin
            chk("b_expected", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) chk("b_resp", 64'(b_resp), 64'(exp_b.pop_front()));
         end
         if (r_valid && r_ready) begin
            chk("r_expected", 64'(exp_r.size() != 0), 64'd1);
            if (exp_r.size() != 0) begin
               logic [33:0] e;
               e = exp_r.pop_front();
               chk("r_data", 64'(r_data), 64'(e[33:2]));
               chk("r_resp", 64'(r_resp), 64'(e[1:0]));
            end
         end
         if (reg_wr != 8'h00) chk("wr_pulse_single", 64'(reg_wr & prev_wr), 64'd0);
         for (int i = 0; i < 8; i++) if (reg_wr[i]) pulses[i]++;
      end
      prev_wr <= reg_wr;
   end

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0;
      bit w_done  = 0;
      exp_b.push_back(exp_resp(a, 1'b1));
      model_write(a, d, s);
      aw_addr = a; aw_valid = 1'b1;
      w_data = d;  w_strb = s; w_valid = 1'b1;
      for (int k = 0; k < 50 && !(aw_done && w_done); k++) begin
         @(negedge clk);
         if (aw_valid && aw_ready) aw_done = 1;
         if (w_valid && w_ready) w_done = 1;
         @(posedge clk); #1;
         if (aw_done) aw_valid = 1'b0;
         if (w_done) w_valid = 1'b0;
      end
      chk("wr_handshake", 64'({aw_done, w_done}), 64'd3);
   endtask

   task automatic read_reg(input logic [31:0] a);
      bit done = 0;
      exp_r.push_back(exp_rd(a));
      ar_addr = a; ar_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (ar_ready) done = 1;
         @(posedge clk); #1;
      end
      ar_valid = 1'b0;
      chk("rd_handshake", 64'(done), 64'd1);
   endtask

   task automatic read_b2b(input int n);
      for (int i = 0; i < n; i++) begin
         ar_addr = 32'(i * 4); ar_valid = 1'b1;
         exp_r.push_back(exp_rd(32'(i * 4)));
         @(negedge clk);
         chk("ar_ready_b2b", 64'(ar_ready), 64'd1);
         if (i > 0) chk("r_valid_b2b", 64'(r_valid), 64'd1);
         @(posedge clk); #1;
      end
      ar_valid = 1'b0;
      @(negedge clk);
      chk("r_valid_b2b_last", 64'(r_valid), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && (exp_b.size() != 0 || exp_r.size() != 0); k++) @(posedge clk);
      #1;
      chk("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
   endtask

   task automatic wait_b_valid();
      for (int k = 0; k < 20 && !b_valid; k++) @(negedge clk);
      chk("b_valid_seen", 64'(b_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      for (int i = 0; i < 8; i++) begin
         model[i]  = '0;
         pulses[i] = 0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_aw_ready", 64'(aw_ready), 64'd1);
      chk("rst_w_ready",  64'(w_ready),  64'd1);
      chk("rst_ar_ready", 64'(ar_ready), 64'd1);
      chk("rst_b_valid",  64'(b_valid),  64'd0);
      chk("rst_r_valid",  64'(r_valid),  64'd0);
      chk("rst_b_resp",   64'(b_resp),   64'd0);
      chk("rst_r_resp",   64'(r_resp),   64'd0);
      chk("rst_r_data",   64'(r_data),   64'd0);
      chk("rst_reg_wr",   64'(reg_wr),   64'd0);
      chk("rst_reg_q_lo", reg_q[63:0],   64'd0);
      @(posedge clk); #1;

      // Read every register back-to-back from reset
      read_b2b(8);
      wait_idle();

      // AW first, W two cycles later; B two cycles after W handshake
      p0 = pulses[1];
      exp_b.push_back(2'b00);
      model_write(32'h4, 32'hDEADBEEF, 4'hF);
      aw_addr = 32'h4; aw_valid = 1'b1;
      @(posedge clk); #1 aw_valid = 1'b0;
      @(posedge clk); #1;
      w_data = 32'hDEADBEEF; w_strb = 4'hF; w_valid = 1'b1;
      @(negedge clk);
      chk("lat_w_ready", 64'(w_ready), 64'd1);
      @(posedge clk); #1 w_valid = 1'b0;
      @(negedge clk);
      chk("lat_b_not_yet", 64'(b_valid), 64'd0);
      @(negedge clk);
      chk("lat_b_valid", 64'(b_valid), 64'd1);
      chk("lat_reg_q1", 64'(reg_q[63:32]), 64'h00000000DEADBEEF);
      chk("lat_reg_wr", 64'(reg_wr), 64'h02);
      @(posedge clk); #1;
      wait_idle();
      chk("pulse_cnt_r1", 64'(pulses[1] - p0), 64'd1);

      // Partial strobe
      write_reg(32'h4, 32'h000000AA, 4'b0001);
      wait_idle();
      chk("strb_reg_q1", 64'(reg_q[63:32]), 64'(model[1]));

      // Error responses
      p0 = pulse_sum();
      write_reg(32'h40, 32'h12345678, 4'hF);
      write_reg(32'h8,  32'h87654321, 4'hF);
      wait_idle();
      chk("err_no_pulse", 64'(pulse_sum() - p0), 64'd0);
      chk("ro_slice_zero", 64'(reg_q[95:64]), 64'd0);
      ro_data[95:64] = 32'h1234;
      read_reg(32'h40);
      read_reg(32'h8);
      read_reg(32'h4);
      wait_idle();

      // All-zero strobe still pulses
      p0 = pulses[0];
      write_reg(32'h0, 32'h55555555, 4'h0);
      wait_idle();
      chk("zero_strb_pulse", 64'(pulses[0] - p0), 64'd1);
      chk("zero_strb_reg0",  64'(reg_q[31:0]), 64'd0);

      // B backpressure: second pair captured, commit coincides with B handshake
      b_ready = 1'b0;
      write_reg(32'hC, 32'h11111111, 4'hF);
      wait_b_valid();
      @(posedge clk); #1;
      write_reg(32'h10, 32'h22222222, 4'hF);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("bp_b_valid",  64'(b_valid),  64'd1);
         chk("bp_b_resp",   64'(b_resp),   64'd0);
         chk("bp_aw_ready", 64'(aw_ready), 64'd0);
         chk("bp_w_ready",  64'(w_ready),  64'd0);
      end
      chk("bp_reg_q3", 64'(reg_q[127:96]),  64'h11111111);
      chk("bp_reg_q4", 64'(reg_q[159:128]), 64'd0);
      @(posedge clk); #1 b_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_second_b",  64'(b_valid), 64'd1);
      chk("bp_reg_q4_new", 64'(reg_q[159:128]), 64'h22222222);
      chk("bp_aw_free",   64'(aw_ready), 64'd1);
      wait_idle();

      // Read in the commit cycle sees old data, next cycle sees new
      @(posedge clk); #1;
      exp_b.push_back(2'b00);
      aw_addr = 32'h14; w_data = 32'h5A5A5A5A; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      @(negedge clk);
      chk("rw_ready", 64'({aw_ready, w_ready}), 64'd3);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      ar_addr = 32'h14; ar_valid = 1'b1;
      exp_r.push_back(exp_rd(32'h14));
      @(posedge clk); #1;
      model_write(32'h14, 32'h5A5A5A5A, 4'hF);
      exp_r.push_back(exp_rd(32'h14));
      @(posedge clk); #1 ar_valid = 1'b0;
      wait_idle();

      // Back-to-back reads with written contents
      read_b2b(8);
      wait_idle();

      // Reset with pending B, full AW slot and pending R
      b_ready = 1'b0; r_ready = 1'b0;
      write_reg(32'h0, 32'hCAFEF00D, 4'hF);
      wait_b_valid();
      @(posedge clk); #1;
      aw_addr = 32'h4; aw_valid = 1'b1;
      ar_addr = 32'h0; ar_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; ar_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_aw_full", 64'(aw_ready), 64'd0);
      chk("pre_rst_r_valid", 64'(r_valid),  64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      exp_b.delete(); exp_r.delete();
      for (int i = 0; i < 8; i++) model[i] = '0;
      @(negedge clk);
      chk("mid_rst_b_valid",  64'(b_valid),  64'd0);
      chk("mid_rst_aw_ready", 64'(aw_ready), 64'd1);
      chk("mid_rst_r_valid",  64'(r_valid),  64'd0);
      chk("mid_rst_r_data",   64'(r_data),   64'd0);
      chk("mid_rst_reg_q",    reg_q[63:0],   64'd0);
      @(posedge clk); #1;
      rst = 1'b0; b_ready = 1'b1; r_ready = 1'b1;
      @(posedge clk); #1;
      read_reg(32'h0);
      write_reg(32'h18, 32'h0BADF00D, 4'hF);
      wait_idle();
      chk("post_rst_reg_q6", 64'(reg_q[223:192]), 64'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
